// File: rtl/mux_route_scheduler.sv
// Round-robin sequencer sharing one mux->demux route among four sources, with a fixed dwell and a dead cycle between routes.
// Optional build macro FIXED_PRIORITY_EN: lowest-index requester always wins instead of round-robin.
module mux_route_scheduler #(
  parameter int DWELL   = 4,
  parameter int DWELL_W = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [7:0] dest_cfg,
  output logic [3:0] gnt,
  output logic [1:0] mux_sel,
  output logic [1:0] demux_sel,
  output logic       route_en,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [3:0]         gnt_d;
  logic [1:0]         mux_sel_d, demux_sel_d;
  logic               route_en_d, busy_d;
  logic [1:0]         start;
  logic [2:0]         pick_res;

  // Returns {found, index} of the first set bit searching upward from start, wrapping.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] s);
    logic       found;
    logic [1:0] idx, win;
    found = 1'b0;
    win   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = s + k[1:0];
      if (r[idx] && !found) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

`ifdef FIXED_PRIORITY_EN
  assign start = 2'd0;
`else
  logic [1:0] last_q, last_d;
  assign start = last_q + 2'd1;
`endif

  assign pick_res = pick(req, start);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt;
    mux_sel_d   = mux_sel;
    demux_sel_d = demux_sel;
    route_en_d  = route_en;
    busy_d      = busy;
`ifndef FIXED_PRIORITY_EN
    last_d      = last_q;
`endif
    case (state_q)
      GRANT: begin
        if (cnt_q == '0 || !req[mux_sel]) begin
          state_d    = GAP;
          gnt_d      = 4'd0;
          route_en_d = 1'b0;
`ifndef FIXED_PRIORITY_EN
          last_d     = mux_sel;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        // IDLE and GAP share arbitration; the selects only move here, while route_en is low.
        if (pick_res[2]) begin
          state_d     = GRANT;
          gnt_d       = 4'b0001 << pick_res[1:0];
          mux_sel_d   = pick_res[1:0];
          demux_sel_d = dest_cfg[2*pick_res[1:0] +: 2];
          route_en_d  = 1'b1;
          busy_d      = 1'b1;
          cnt_d       = DWELL_W'(DWELL - 1);
        end else begin
          state_d    = IDLE;
          gnt_d      = 4'd0;
          route_en_d = 1'b0;
          busy_d     = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      gnt       <= 4'd0;
      mux_sel   <= 2'd0;
      demux_sel <= 2'd0;
      route_en  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt       <= gnt_d;
      mux_sel   <= mux_sel_d;
      demux_sel <= demux_sel_d;
      route_en  <= route_en_d;
      busy      <= busy_d;
    end
  end

`ifndef FIXED_PRIORITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 2'd3;
    else        last_q <= last_d;
  end
`endif

endmodule
